stack_ram_responder: RTL
========================

Name: stack_ram_responder

Overview:
- Memory-side responder for the stack calculator's memory bus: 128 x 8 synchronous RAM answering cs/we/address/write-data requests from the control FSM.
- Provides 1-cycle registered read data with a valid strobe.
- Includes a hardware clear engine that zero-fills the array after reset or on request, flagged by busy.
- Sits between the control block and the display/debug path, replacing an inferred bare RAM.

Parameters:
- ADDR_W, 7, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 128, number of words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cs, in, 1, chip select; a request is accepted on a rising edge when cs=1 and busy=0.
- we, in, 1, 1 = write, 0 = read; qualified by cs.
- address, in, ADDR_W, word address.
- data_in, in, DATA_W, write data (driven by the control block's data_out).
- clr, in, 1, level-sampled request to start a clear sweep.
- data_out, out, DATA_W, registered read or write-through data.
- rd_valid, out, 1, one-cycle pulse; data_out is updated in the same cycle.
- busy, out, 1, high while the clear sweep runs; requests are ignored while high.

Behaviour:
Reset (rst_n=0, asynchronous):
- data_out=0, rd_valid=0, busy=1, state=SWEEP, sweep_ptr=0.
- Array contents are not reset directly; the sweep clears them after reset is released.

State SWEEP:
- Each cycle: mem[sweep_ptr] <= 0 and sweep_ptr increments.
- On the cycle sweep_ptr == DEPTH-1, the final word is written, state goes to IDLE, and busy is 0 from the next cycle.
- busy is therefore high for exactly DEPTH cycles after reset release.
- cs is ignored while busy. rd_valid stays 0. data_out holds its value (0 after reset).
- clr asserted during SWEEP restarts the sweep: sweep_ptr=0 and a full DEPTH-cycle sweep follows.

State IDLE:
- clr=1: go to SWEEP with sweep_ptr=0 and busy=1 next cycle. clr has priority, so a cs request in the same cycle is dropped (no write, no rd_valid).
- cs=1, we=1: mem[address] <= data_in; data_out <= data_in (write-through); rd_valid=1 next cycle.
- cs=1, we=0: data_out <= mem[address]; rd_valid=1 next cycle. Read latency is 1 cycle.
- cs=0: data_out holds its value; rd_valid=0.

Boundary conditions:
- Back-to-back requests are accepted every cycle; there are no wait states in IDLE.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Write and read to the same address in the same cycle cannot occur (single port).
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W): writes are discarded; reads return 0 with rd_valid=1.
- Address wrap is the client's responsibility; the block does no arithmetic on address.
- If reset is asserted mid-sweep or mid-access, the block restarts the full sweep after release.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from data_in on write.
  - An extra input par_inj (1 bit) inverts the stored parity bit when it is high during a write.
  - An extra output parity_err (1 bit) pulses together with rd_valid on a read whose recomputed parity mismatches the stored bit.
  - The sweep writes 0 data with correct parity (0).
  - Write-through cycles never flag an error.
  - parity_err resets to 0.
- Undefined: par_inj and parity_err ports are absent; the array is DATA_W wide.

Test Plan:
- Reset, release, hold cs=0 -> busy=1 for exactly 128 cycles then 0; reads of addresses 0x00, 0x7F, 0x40 return 0x00 with rd_valid one cycle after cs.
- Write 0xA5 to 0x7F, then read 0x7F on the next cycle -> data_out=0xA5 with rd_valid on the write cycle+1 and the read cycle+1.
- Write 0x11, 0x22, 0x33 to 0x7F, 0x7E, 0x7D on back-to-back cycles, then read 0x7E -> data_out=0x22; data_out/rd_valid track every cycle.
- Write 0x5A to 0x10; assert clr with cs=1 we=1 address 0x11 data 0xFF in the same cycle -> no write to 0x11; busy for 128 cycles; read 0x10 -> 0x00, read 0x11 -> 0x00.
- Assert rst_n=0 mid-sweep (cycle 60), release -> busy high a full 128 cycles from release; requests issued during busy produce no rd_valid.
- With MEM_PARITY_EN defined: write 0x07 to 0x05 with par_inj=1, read 0x05 -> data_out=0x07, parity_err=1; rewrite with par_inj=0, read -> parity_err=0.

Source files
------------

// File: rtl/stack_ram_responder_if.sv
// Request/response bus between the stack calculator control FSM and its RAM responder.
// MEM_PARITY_EN adds the parity-inject input and parity-error output.
interface stack_ram_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              clr;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
`ifdef MEM_PARITY_EN
    logic              par_inj;
    logic              parity_err;
`endif

    modport master (
        output cs, we, address, data_in, clr,
`ifdef MEM_PARITY_EN
        output par_inj,
        input  parity_err,
`endif
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  cs, we, address, data_in, clr,
`ifdef MEM_PARITY_EN
        input  par_inj,
        output parity_err,
`endif
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/stack_ram_responder.sv
// DEPTH x DATA_W single-port RAM responder: 1-cycle registered read/write-through with rd_valid,
// zero-fill sweep after reset or clr (busy high, requests dropped). Optional MEM_PARITY_EN parity.
module stack_ram_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128
) (
    input logic                 clk,
    input logic                 rst_n,
    stack_ram_responder_if.slave bus
);
`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep_ptr;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign in_range = ({1'b0, bus.address} < DEPTH_W);
    assign accept   = (state == IDLE) && bus.cs && !bus.clr;

`ifdef MEM_PARITY_EN
    // Stored bit makes the word even parity; par_inj deliberately corrupts it.
    assign wr_word = {(^bus.data_in) ^ bus.par_inj, bus.data_in};
`else
    assign wr_word = bus.data_in;
`endif

    assign rd_word = in_range ? mem[bus.address] : '0;

    // The sweep owns the single write port; client writes only land in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.address;
        mem_wdata = wr_word;
        if (state == SWEEP) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_ptr;
            mem_wdata = '0;
        end else if (accept && bus.we && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SWEEP;
            sweep_ptr    <= '0;
            bus.busy     <= 1'b1;
            bus.data_out <= '0;
            bus.rd_valid <= 1'b0;
`ifdef MEM_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= 1'b0;
`ifdef MEM_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
            case (state)
                SWEEP: begin
                    if (bus.clr) begin
                        sweep_ptr <= '0;
                    end else if (sweep_ptr == LAST) begin
                        sweep_ptr <= '0;
                        state     <= IDLE;
                        bus.busy  <= 1'b0;
                    end else begin
                        sweep_ptr <= sweep_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clr) begin
                        state     <= SWEEP;
                        sweep_ptr <= '0;
                        bus.busy  <= 1'b1;
                    end else if (bus.cs) begin
                        bus.rd_valid <= 1'b1;
                        if (bus.we) begin
                            bus.data_out <= bus.data_in;
                        end else begin
                            bus.data_out <= rd_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
                            bus.parity_err <= ^rd_word;
`endif
                        end
                    end
                end
                default: begin
                    state    <= SWEEP;
                    bus.busy <= 1'b1;
                end
            endcase
        end
    end
endmodule
